// File: rtl/spi_sclk_timer.sv
// SPI master transfer timing: divides pclk into SCLK half-periods and frames one
// character as lead, 2*N toggle edges and trail, with per-edge shift/sample strobes.
module spi_sclk_timer #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 7
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] char_len,
  input  logic             cpha,
  output logic             transfer,
  output logic             en_tgl,
  output logic             load_pulse,
  output logic             shift_pulse,
  output logic             sample_pulse,
  output logic             busy,
  output logic             done
);

  localparam int KW = LEN_W + 2;

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]      k_q, k_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               cpha_q, cpha_d;
  logic               done_q, done_d;

  logic               tick, accept, last_edge, odd_edge;
  logic [LEN_W:0]     n_chars;
  logic [KW-1:0]      k_last;

  assign tick      = (cnt_q == div_q);
  assign accept    = (state_q == IDLE) && start && !abort;
  assign n_chars   = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};
  assign k_last    = {n_chars, 1'b0} - KW'(1);
  // k_q holds toggles already issued, so the current toggle is k_q+1
  assign last_edge = (k_q == k_last);
  assign odd_edge  = !k_q[0];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      div_q   <= '0;
      len_q   <= '0;
      cpha_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      div_q   <= div_d;
      len_q   <= len_d;
      cpha_q  <= cpha_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = LEAD;
      LEAD:  if (abort) state_d = IDLE; else if (tick) state_d = XFER;
      XFER:  if (abort) state_d = IDLE; else if (tick && last_edge) state_d = TRAIL;
      TRAIL: if (abort || tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = (state_q == IDLE || state_d != state_q || tick) ? '0 : cnt_q + DIV_W'(1);
    k_d    = k_q;
    if (state_q == IDLE)          k_d = '0;
    else if (state_q == XFER && tick) k_d = k_q + KW'(1);
    div_d  = accept ? div      : div_q;
    len_d  = accept ? char_len : len_q;
    cpha_d = accept ? cpha     : cpha_q;
    done_d = (state_q == TRAIL) && tick && !abort;
  end

  always_comb begin
    transfer     = (state_q != IDLE);
    busy         = transfer;
    en_tgl       = (state_q == XFER) && tick;
    // acceptance strobe lets the shift register capture the character before LEAD
    load_pulse   = accept && presetn;
    shift_pulse  = 1'b0;
    sample_pulse = 1'b0;
    if (cpha_q) begin
      shift_pulse  = en_tgl && odd_edge;
      sample_pulse = en_tgl && !odd_edge;
    end else begin
      sample_pulse = en_tgl && odd_edge;
      shift_pulse  = en_tgl && !odd_edge && !last_edge;
    end
    done         = done_q;
  end

endmodule
